branch_resolve_unit: RTL
========================

# branch_resolve_unit

ID-stage branch resolution and fetch-redirect unit for the 5-stage pipeline. Consumes the BLTZ opcode decode in ID, waits out data hazards on `rs`, evaluates the condition, and on a taken branch drives a registered PC redirect plus IF/ID and ID/EX flushes one cycle later. The fetch policy is predict-not-taken with no delay slot. It also keeps saturating branch statistics counters for the performance-debug bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC / data width.
- `COUNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `id_valid`  in  1  instruction in ID is valid (not a bubble).
- `id_instr`  in  32  instruction in ID; opcode `[31:26]`, rs `[25:21]`, imm `[15:0]`.
- `id_pc_plus4`  in  ADDR_WIDTH  PC+4 of the ID instruction.
- `rs_data`  in  ADDR_WIDTH  register-file read of rs (write-before-read, so WB needs no hazard check).
- `ex_regwrite`, `ex_rd`  in  1, 5  EX-stage destination.
- `mem_regwrite`, `mem_rd`  in  1, 5  MEM-stage destination.
- `stall`  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational).
- `flush_ifid`  out  1  zero IF/ID on the next edge (registered).
- `flush_idex`  out  1  zero ID/EX on the next edge (registered).
- `redirect_valid`  out  1  PC mux selects `redirect_pc` (registered).
- `redirect_pc`  out  ADDR_WIDTH  branch target (registered).
- `branch_count`  out  COUNT_WIDTH  resolved branches, saturating.
- `taken_count`  out  COUNT_WIDTH  taken branches, saturating.

## Operation
- **Branch detect:** `is_br = id_valid && id_instr[31:26] == 6'b000001`. The decode uses the opcode only; rt is not examined.
- **Hazard:** `haz = (ex_regwrite && ex_rd == rs) || (mem_regwrite && mem_rd == rs)`, and is forced to 0 when rs == 0.
- **Condition and target:**
  - Taken when `rs_data[ADDR_WIDTH-1] == 1` (rs < 0, signed).
  - `target = id_pc_plus4 + (sign_ext(imm) << 2)`, computed mod 2^ADDR_WIDTH; wrap-around is ignored.
- **FSM with two states, IDLE and REDIRECT:**
  - **IDLE:**
    - `stall = is_br && haz`. There is no cap on stall cycles; the branch is re-evaluated every cycle.
    - The branch resolves when `is_br && !haz`. Both counters update on resolve; `taken_count` increments only if taken.
    - Resolved taken: load `redirect_pc <= target` and go to REDIRECT.
    - Resolved not taken: stay in IDLE; no outputs change.
  - **REDIRECT (exactly one cycle):**
    - `redirect_valid = flush_ifid = flush_idex = 1`.
    - `stall` is forced to 0.
    - `id_*` inputs are ignored: the ID instruction is on the wrong path, and a BLTZ there is neither resolved nor counted.
    - Next state is IDLE unconditionally.
- **Counters:** saturate at all-ones and never wrap.
- **Reset (asynchronous, any time, including mid-REDIRECT):**
  - state = IDLE.
  - `redirect_valid`, `flush_ifid`, `flush_idex` = 0.
  - `redirect_pc` = 0.
  - Both counters = 0.
  - `stall` follows its combinational equation (0 while in IDLE with no branch).

## Timing
- **Resolve cycle N** (branch in ID, no hazard): not-taken has zero penalty.
- **Taken branch:**
  - In N+1: `redirect_valid`, `flush_ifid`, `flush_idex` high for exactly one cycle, and `redirect_pc` is valid.
  - At the N+1 edge: PC loads the target, IF/ID drops the PC+8 fetch, and ID/EX drops the PC+4 instruction.
  - The target instruction is in IF at N+2. Penalty is 2 cycles.
- **Hazard:** `stall` asserts in the same cycle as `is_br && haz`. Resolution occurs in the first cycle haz = 0. An EX-producer hazard costs 2 stall cycles; a MEM-producer hazard costs 1.
- **Counter updates:** visible the cycle after resolve.
- **Back-to-back branches:** a branch in ID at N+1 is the wrong-path instruction and is discarded. The earliest next resolve is N+2.

## Test plan
- BLTZ with `rs_data = 32'h0000_0005`, no hazard → no stall and no redirect. Next cycle `branch_count = 1`, `taken_count = 0`.
- BLTZ with `rs_data = 32'hFFFF_FFFC`, `id_pc_plus4 = 32'h0000_0100`, imm = `16'hFFFE` → next cycle one-cycle pulse on `redirect_valid`, `flush_ifid`, `flush_idex` with `redirect_pc = 32'h0000_00F8`. Then `taken_count = 1`.
- BLTZ with rs = 8, `ex_rd = 8`, `ex_regwrite = 1` (moving to MEM next cycle) → `stall` high for 2 cycles, resolve on the 3rd. Counters increment once only.
- BLTZ with rs = 0, `ex_rd = 0`, `ex_regwrite = 1` → no stall; resolves immediately as not-taken.
- Taken BLTZ followed immediately by another taken BLTZ in ID during REDIRECT → only one redirect pulse, `branch_count` increments by 1. Asserting reset during REDIRECT clears all outputs and counters asynchronously.
- Preload via 65535 resolved taken branches, then resolve one more → `branch_count` and `taken_count` hold at `16'hFFFF`.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ID-stage BLTZ resolution: waits out rs hazards, evaluates rs < 0, and issues a
// one-cycle registered PC redirect plus IF/ID and ID/EX flushes for taken branches.
module branch_resolve_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic [ADDR_WIDTH-1:0]  id_pc_plus4,
  input  logic [ADDR_WIDTH-1:0]  rs_data,
  input  logic                   ex_regwrite,
  input  logic [4:0]             ex_rd,
  input  logic                   mem_regwrite,
  input  logic [4:0]             mem_rd,
  output logic                   stall,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   redirect_valid,
  output logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  localparam logic [5:0] OPC_BLTZ = 6'b000001;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [COUNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [COUNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic [4:0]             rs;
  logic [15:0]            imm;
  logic                   is_br;
  logic                   haz;
  logic                   taken;
  logic [ADDR_WIDTH-1:0]  imm_ext;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   unused_rt;

  // rt is not part of the decode; BLTZ is recognised by opcode alone.
  assign unused_rt = ^id_instr[20:16];

  assign rs      = id_instr[25:21];
  assign imm     = id_instr[15:0];
  assign is_br   = id_valid && (id_instr[31:26] == OPC_BLTZ);
  assign haz     = (rs != 5'd0) &&
                   ((ex_regwrite && (ex_rd == rs)) || (mem_regwrite && (mem_rd == rs)));
  assign taken   = rs_data[ADDR_WIDTH-1];
  assign imm_ext = {{(ADDR_WIDTH-16){imm[15]}}, imm};
  assign target  = id_pc_plus4 + (imm_ext << 2);

  // Next-state, stall and counter update.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;
    stall            = 1'b0;
    case (state_q)
      IDLE: begin
        stall = is_br && haz;
        if (is_br && !haz) begin
          if (branch_cnt_q != {COUNT_WIDTH{1'b1}}) begin
            branch_cnt_d = branch_cnt_q + COUNT_WIDTH'(1);
          end
          if (taken) begin
            if (taken_cnt_q != {COUNT_WIDTH{1'b1}}) begin
              taken_cnt_d = taken_cnt_q + COUNT_WIDTH'(1);
            end
            redirect_pc_d    = target;
            redirect_valid_d = 1'b1;
            state_d          = REDIRECT;
          end
        end
      end
      // ID holds a wrong-path instruction here; it is ignored entirely.
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush_ifid     = redirect_valid_q;
  assign flush_idex     = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_count   = branch_cnt_q;
  assign taken_count    = taken_cnt_q;

endmodule
